// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared encodings and constants for the fetch stage
package fetch_stage_pkg;
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_e;
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_VALID = 2'b01,
    S_HALT  = 2'b10
  } state_e;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_pc_next.sv
// pc_next: combinational next-PC mux and adders, all arithmetic modulo 2^32
module pc_next
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] immExt,
  input  logic [31:0] aluResult,
  input  logic [1:0]  pcSrc,
  output logic [31:0] pcPlus4,
  output logic [31:0] pcTarget,
  output logic [31:0] nextPc
);
  assign pcPlus4  = pc + 32'd4;
  assign pcTarget = pc + immExt;
  // reserved encoding falls back to sequential fetch
  always_comb
    nextPc = pcSrc == PC_BRANCH ? pcTarget :
             pcSrc == PC_JALR   ? (aluResult & ~32'h1) : pcPlus4;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: FETCH/VALID/HALT instruction fetch with held instruction toward decode.
// Define MISALIGN_TRAP_EN to halt on a misaligned next PC instead of forcing alignment.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] immExt,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] aluResult,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        imemAck,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] pcTarget,
  output logic        misaligned
);
  state_e      state_q;
  logic [31:0] pc_q, instr_q, next_pc, pc_d;
  pc_next u_pc_next (
    .pc        (pc_q),
    .immExt    (immExt),
    .aluResult (aluResult),
    .pcSrc     (pcSrc),
    .pcPlus4   (pcPlus4),
    .pcTarget  (pcTarget),
    .nextPc    (next_pc)
  );
`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign pc_d       = next_pc;
  assign misaligned = mis_q;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      mis_q   <= 1'b0;
    end else if (state_q == S_FETCH && imemAck) begin
      instr_q <= imemRdata;
      state_q <= S_VALID;
    end else if (state_q == S_VALID && !stall) begin
      // a misaligned target freezes the PC and parks the stage until reset
      if (pc_d[1:0] != 2'b00) begin
        mis_q   <= 1'b1;
        state_q <= S_HALT;
      end else begin
        pc_q    <= pc_d;
        state_q <= S_FETCH;
      end
    end
`else
  assign pc_d       = next_pc & ~32'h3;
  assign misaligned = 1'b0;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
    end else if (state_q == S_FETCH && imemAck) begin
      instr_q <= imemRdata;
      state_q <= S_VALID;
    end else if (state_q == S_VALID && !stall) begin
      pc_q    <= pc_d;
      state_q <= S_FETCH;
    end
`endif
  // request drops during reset so an in-flight fetch is abandoned
  assign imemReq    = state_q == S_FETCH && !reset;
  assign instrValid = state_q == S_VALID;
  assign imemAddr   = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage (expected fetches queued at ack time)
module tb_fetch_stage;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b1, imemAck = 1'b0;
  logic [1:0]  pcSrc = 2'b00;
  logic [31:0] immExt = '0, aluResult = '0, imemRdata = '0;
  logic        imemReq, instrValid, misaligned;
  logic [31:0] imemAddr, instr, pc, pcPlus4, pcTarget;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_instr = 32'h13;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .immExt     (immExt),
    .pcSrc      (pcSrc),
    .aluResult  (aluResult),
    .stall      (stall),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemRdata  (imemRdata),
    .imemAck    (imemAck),
    .instr      (instr),
    .instrValid (instrValid),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .pcTarget   (pcTarget),
    .misaligned (misaligned)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] data, input int lat);
    exp_t e;
    int   n = 0;
    while (!imemReq && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", imemReq, 1);
    if (!imemReq) return;
    repeat (lat) begin
      check("valid_while_wait", instrValid, 0);
      @(negedge clk);
    end
    sb.push_back('{model_pc, data});
    imemAck   = 1'b1;
    imemRdata = data;
    @(negedge clk);
    imemAck   = 1'b0;
    imemRdata = $urandom;
    n = 0;
    while (!instrValid && n < 10) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    model_instr = e.instr;
    check("fetch_valid", instrValid, 1);
    check("fetch_instr", instr, e.instr);
    check("fetch_pc", pc, e.pc);
    check("fetch_addr", imemAddr, e.pc);
    check("fetch_req_low", imemReq, 0);
  endtask
  task automatic advance(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] m;
    pcSrc = src;
    immExt = imm;
    aluResult = alu;
    stall = 1'b0;
    #1;
    check("pcPlus4", pcPlus4, model_pc + 32'd4);
    check("pcTarget", pcTarget, model_pc + imm);
    m = src == 2'b01 ? model_pc + imm : src == 2'b10 ? {alu[31:1], 1'b0} : model_pc + 32'd4;
    @(negedge clk);
    stall = 1'b1;
    pcSrc = 2'($urandom_range(3));
    immExt = $urandom;
    aluResult = $urandom;
`ifdef MISALIGN_TRAP_EN
    if (m[1:0] != 2'b00) begin
      check("halt_mis", misaligned, 1);
      check("halt_pc", pc, model_pc);
      check("halt_req", imemReq, 0);
      check("halt_valid", instrValid, 0);
      return;
    end
`else
    m = {m[31:2], 2'b00};
`endif
    model_pc = m;
    check("adv_pc", pc, m);
    check("adv_addr", imemAddr, m);
    check("adv_mis", misaligned, 0);
    check("adv_valid", instrValid, 0);
    check("adv_req", imemReq, 1);
  endtask
  initial begin
    imemAck = 1'b1;
    imemRdata = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    check("rst_req", imemReq, 0);
    check("rst_valid", instrValid, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h13);
    check("rst_mis", misaligned, 0);
    imemAck = 1'b0;
    reset = 1'b0;
    #1 check("req_after_rst", imemReq, 1);
    fetch(32'h0050_0093, 1);
    advance(2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      fetch($urandom, int'($urandom_range(2)));
      advance(2'b00, $urandom, $urandom);
    end
    fetch(32'h1234_5678, 0);
    advance(2'b01, 32'hFFFF_FFF8, 32'h0);
    check("branch_back_addr", imemAddr, 32'h8);
    fetch(32'hCAFE_0001, 2);
    repeat (3) begin
      imemAck = 1'b1;
      imemRdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stall_pc", pc, model_pc);
      check("stall_instr", instr, model_instr);
      check("stall_valid", instrValid, 1);
    end
    imemAck = 1'b0;
    advance(2'b00, 32'h0, 32'h0);
    fetch(32'hCAFE_0002, 1);
    advance(2'b10, 32'h0, 32'h0000_0101);
    check("jalr_pc", pc, 32'h100);
    fetch(32'hCAFE_0003, 0);
    advance(2'b11, 32'h40, 32'h0);
    reset = 1'b1;
    imemAck = 1'b1;
    imemRdata = 32'hBAD1_BAD1;
    #1 check("midrst_req", imemReq, 0);
    @(negedge clk);
    reset = 1'b0;
    imemAck = 1'b0;
    model_pc = 32'h0;
    check("midrst_valid", instrValid, 0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_instr", instr, 32'h13);
    #1 check("midrst_newreq", imemReq, 1);
    fetch(32'hCAFE_0004, 1);
    advance(2'b10, 32'h0, 32'hFFFF_FFFC);
    fetch(32'hCAFE_0005, 0);
    advance(2'b00, 32'h0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    fetch(32'hCAFE_0006, 1);
    advance(2'b01, 32'h6, 32'h0);
`ifdef MISALIGN_TRAP_EN
    repeat (3) begin
      imemAck = 1'b1;
      @(negedge clk);
      check("halt_hold_pc", pc, 32'h0);
      check("halt_hold_req", imemReq, 0);
      check("halt_hold_mis", misaligned, 1);
    end
    imemAck = 1'b0;
`else
    check("mis_forced_pc", pc, 32'h4);
    fetch(32'hCAFE_0007, 0);
`endif
    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
